// File: rtl/ft245_tx_arbiter.sv
// ============================================================================
// ft245_tx_arbiter
// ----------------------------------------------------------------------------
// Shares the FT245 asynchronous-FIFO write port between N_SRC byte-stream
// requesters. A requester is picked by round-robin arbitration. It then sends
// a burst of at most BURST_MAX bytes before the arbiter picks again. Each byte
// is written with one registered wr_n low strobe, and only when txe_n reports
// that the FIFO has space.
//
// Per-byte sequence inside a burst: WAIT_TXE -> STROBE -> HOLD. This takes
// 3 cycles per byte. One IDLE cycle separates consecutive grants.
//
// Parameters:
//   N_SRC      number of requesters (2..8)
//   IDW        width of grant_id, equal to clog2(N_SRC)
//   BURST_MAX  maximum bytes per grant (1..255)
//
// Ports:
//   clock_in   system clock, rising edge
//   reset_n    asynchronous active-low reset
//   txe_n      FT245 TX-FIFO-full flag (low = space), synchronous to clock_in
//   data_out   FT245 data bus (registered)
//   wr_n       FT245 write strobe, active low (registered)
//   src_valid  per-source byte available
//   src_data   per-source byte, source k at [8k+7:8k]
//   src_ready  per-source accept (combinational). A byte transfers on the
//              clock edge where src_valid and src_ready are both high.
//   grant_id   index of the currently granted source (registered)
//   busy       high whenever the arbiter is not in IDLE
//
// Build option:
//   ARB_FIXED_PRIORITY_EN  When this macro is defined, IDLE grants the
//                          lowest-index valid source (source 0 has the
//                          highest priority) and ignores the last grant.
//                          When it is undefined, arbitration is round-robin.
// ============================================================================
module ft245_tx_arbiter #(
    parameter int N_SRC     = 4,
    parameter int IDW       = 2,
    parameter int BURST_MAX = 16
) (
    input  logic                 clock_in,
    input  logic                 reset_n,
    input  logic                 txe_n,
    output logic [7:0]           data_out,
    output logic                 wr_n,
    input  logic [N_SRC-1:0]     src_valid,
    input  logic [8*N_SRC-1:0]   src_data,
    output logic [N_SRC-1:0]     src_ready,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_TXE = 2'd1,
        STROBE   = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t         state_q,      state_d;
    logic [IDW-1:0] grant_id_q,   grant_id_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic [7:0]     burst_cnt_q,  burst_cnt_d;
    logic [7:0]     data_out_q,   data_out_d;
    logic           wr_n_q,       wr_n_d;

    // Split the packed data bus into one byte lane per source.
    logic [7:0] src_byte [N_SRC];

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        assign src_byte[gi]  = src_data[8*gi +: 8];
        // Only the granted source can see ready, and only while waiting
        // for FIFO space.
        assign src_ready[gi] = (state_q == WAIT_TXE) && (grant_id_q == IDW'(gi))
                               && !txe_n && src_valid[gi];
    end

    logic       sel_valid;
    logic [7:0] sel_byte;
    assign sel_valid = src_valid[grant_id_q];
    assign sel_byte  = src_byte[grant_id_q];

    // ------------------------------------------------------------------
    // Arbitration pick
    // ------------------------------------------------------------------
    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic [IDW-1:0] cand;
    logic [IDW:0]   cand_sum;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        cand_sum   = '0;
`ifdef ARB_FIXED_PRIORITY_EN
        // The scan runs from the highest index down, so the last hit is
        // the lowest-index valid source.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            cand = IDW'(i);
            if (src_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
`else
        // The search starts one past the last grant and wraps modulo
        // N_SRC. One extra bit of width keeps the wrap correct even when
        // N_SRC is not a power of two.
        for (int i = 1; i <= N_SRC; i++) begin
            cand_sum = {1'b0, last_grant_q} + (IDW+1)'(i);
            if (cand_sum >= (IDW+1)'(N_SRC)) begin
                cand_sum = cand_sum - (IDW+1)'(N_SRC);
            end
            cand = cand_sum[IDW-1:0];
            if (!pick_found && src_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        data_out_d   = data_out_q;
        wr_n_d       = 1'b1;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_id_d  = pick_idx;
                    burst_cnt_d = 8'd0;
                    state_d     = WAIT_TXE;
                end
            end

            WAIT_TXE: begin
                if (!sel_valid) begin
                    // The source has gone quiet, so the burst ends even if
                    // no byte was sent.
                    last_grant_d = grant_id_q;
                    state_d      = IDLE;
                end else if (!txe_n) begin
                    data_out_d = sel_byte;
                    wr_n_d     = 1'b0;
                    state_d    = STROBE;
                end
            end

            STROBE: begin
                // The write is committed at this point, so txe_n is
                // ignored here.
                burst_cnt_d = burst_cnt_q + 8'd1;
                state_d     = HOLD;
            end

            HOLD: begin
                // wr_n stays high for one cycle so the FT245 can update
                // txe_n before the next byte.
                if ((burst_cnt_q == 8'(BURST_MAX)) || !sel_valid) begin
                    last_grant_d = grant_id_q;
                    state_d      = IDLE;
                end else begin
                    state_d = WAIT_TXE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            // Start the last grant at N_SRC-1 so that source 0 wins first.
            last_grant_q <= IDW'(N_SRC - 1);
            burst_cnt_q  <= 8'd0;
            data_out_q   <= 8'd0;
            wr_n_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            data_out_q   <= data_out_d;
            wr_n_q       <= wr_n_d;
        end
    end

    assign data_out = data_out_q;
    assign wr_n     = wr_n_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ft245_tx_arbiter.sv
// ============================================================================
// tb_ft245_tx_arbiter
// ----------------------------------------------------------------------------
// Directed bench for ft245_tx_arbiter. Two instances share the same inputs:
// d_* has BURST_MAX=16 and b_* has BURST_MAX=2. Each scenario checks the
// instance that suits it.
// ============================================================================
module tb_ft245_tx_arbiter;

    logic        clk;
    logic        reset_n;
    logic        txe_n;
    logic [3:0]  src_valid;
    logic [31:0] src_data;

    logic [7:0]  d_data_out, b_data_out;
    logic        d_wr_n,     b_wr_n;
    logic [3:0]  d_src_ready, b_src_ready;
    logic [1:0]  d_grant_id, b_grant_id;
    logic        d_busy,     b_busy;

    int n_cmp;
    int n_err;

    logic [31:0] st_g [16];
    logic [31:0] st_c [16];
    logic [31:0] st_d [16];
    int          n_st;
    int          n_g1;

    ft245_tx_arbiter #(.N_SRC(4), .IDW(2), .BURST_MAX(16)) dut_d (
        .clock_in (clk),
        .reset_n  (reset_n),
        .txe_n    (txe_n),
        .data_out (d_data_out),
        .wr_n     (d_wr_n),
        .src_valid(src_valid),
        .src_data (src_data),
        .src_ready(d_src_ready),
        .grant_id (d_grant_id),
        .busy     (d_busy)
    );

    ft245_tx_arbiter #(.N_SRC(4), .IDW(2), .BURST_MAX(2)) dut_b (
        .clock_in (clk),
        .reset_n  (reset_n),
        .txe_n    (txe_n),
        .data_out (b_data_out),
        .wr_n     (b_wr_n),
        .src_valid(src_valid),
        .src_data (src_data),
        .src_ready(b_src_ready),
        .grant_id (b_grant_id),
        .busy     (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        txe_n     = 1'b1;
        src_valid = 4'b0000;
        src_data  = 32'h0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic clear_log();
        for (int i = 0; i < 16; i++) begin
            st_g[i] = 'x;
            st_c[i] = 'x;
            st_d[i] = 'x;
        end
        n_st = 0;
    endtask

    // Expected strobe cycles and grants for four continuous sources with
    // BURST_MAX=2. Each grant costs 7 cycles: I, W, S, H, W, S, H.
    int exp_c [10] = '{2, 5, 9, 12, 16, 19, 23, 26, 30, 33};
    int exp_g [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
`ifdef ARB_FIXED_PRIORITY_EN
    int exp_pg [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    int exp_pg [8] = '{0, 0, 2, 2, 0, 0, 2, 2};
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;

        // ---------------- Reset state ----------------
        do_reset();
        check("rst_wr_n",  32'(d_wr_n),      32'h1);
        check("rst_data",  32'(d_data_out),  32'h0);
        check("rst_ready", 32'(d_src_ready), 32'h0);
        check("rst_grant", 32'(d_grant_id),  32'h0);
        check("rst_busy",  32'(d_busy),      32'h0);
        $display("txn reset: wr_n=%0d data=%02h busy=%0d", d_wr_n, d_data_out, d_busy);

        // ---------------- Single byte from source 0 ----------------
        txe_n     = 1'b0;
        src_valid = 4'b0001;
        src_data  = 32'h0000_00A5;
        tick();
        check("t1_grant", 32'(d_grant_id),  32'h0);
        check("t1_busy",  32'(d_busy),      32'h1);
        check("t1_wr_w",  32'(d_wr_n),      32'h1);
        check("t1_ready", 32'(d_src_ready), 32'h1);
        tick();
        check("t1_wr_s",   32'(d_wr_n),     32'h0);
        check("t1_data_s", 32'(d_data_out), 32'hA5);
        src_valid = 4'b0000;
        tick();
        check("t1_wr_h",   32'(d_wr_n),     32'h1);
        check("t1_data_h", 32'(d_data_out), 32'hA5);
        tick();
        check("t1_idle", 32'(d_busy), 32'h0);
        check("t1_wr_i", 32'(d_wr_n), 32'h1);
        $display("txn single: data=%02h grant=%0d", d_data_out, d_grant_id);

        // ---------------- Round-robin, four sources, BURST_MAX=2 ----------------
        do_reset();
        txe_n     = 1'b0;
        src_valid = 4'b1111;
        src_data  = 32'h1312_1110;
        clear_log();
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (b_wr_n == 1'b0 && n_st < 16) begin
                st_g[n_st] = 32'(b_grant_id);
                st_c[n_st] = 32'(c);
                st_d[n_st] = 32'(b_data_out);
                n_st++;
            end
        end
        check("rr_count", 32'(n_st), 32'd10);
        for (int k = 0; k < 10; k++) begin
            check("rr_grant", st_g[k], 32'(exp_g[k]));
            check("rr_cycle", st_c[k], 32'(exp_c[k]));
            check("rr_data",  st_d[k], 32'h10 + 32'(exp_g[k]));
            $display("txn rr strobe %0d: cycle=%0d grant=%0d data=%02h", k, st_c[k], st_g[k], st_d[k]);
        end

        // ---------------- txe_n stall, source 2 ----------------
        do_reset();
        txe_n     = 1'b0;
        src_valid = 4'b0100;
        src_data  = 32'h0055_0000;
        tick();
        check("st_grant", 32'(d_grant_id), 32'h2);
        tick();
        check("st_wr1",   32'(d_wr_n),     32'h0);
        check("st_data1", 32'(d_data_out), 32'h55);
        tick();
        txe_n    = 1'b1;
        src_data = 32'h0056_0000;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("st_ready_hold", 32'(d_src_ready), 32'h0);
            check("st_wr_hold",    32'(d_wr_n),      32'h1);
            if (i < 9) tick();
        end
        txe_n = 1'b0;
        #1;
        check("st_ready_rel", 32'(d_src_ready), 32'h4);
        tick();
        check("st_wr2",   32'(d_wr_n),     32'h0);
        check("st_data2", 32'(d_data_out), 32'h56);
        $display("txn stall: data=%02h wr_n=%0d", d_data_out, d_wr_n);

        // ---------------- Source 1 drops after 3 bytes, source 3 pending ----------------
        do_reset();
        txe_n     = 1'b0;
        src_valid = 4'b1010;
        src_data  = 32'h3300_1100;
        n_g1      = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (d_wr_n == 1'b0 && d_grant_id == 2'd1) n_g1++;
        end
        check("dr_count", 32'(n_g1),   32'd3);
        check("dr_wr3",   32'(d_wr_n), 32'h0);
        src_valid = 4'b1000;
        tick();
        check("dr_hold", 32'(d_busy), 32'h1);
        tick();
        check("dr_idle", 32'(d_busy), 32'h0);
        tick();
        check("dr_grant3", 32'(d_grant_id), 32'h3);
        tick();
        check("dr_wr_s3",   32'(d_wr_n),     32'h0);
        check("dr_data_s3", 32'(d_data_out), 32'h33);
        $display("txn drop: strobes_src1=%0d next_grant=%0d", n_g1, d_grant_id);

        // ---------------- Reset during STROBE ----------------
        do_reset();
        txe_n     = 1'b0;
        src_valid = 4'b0100;
        src_data  = 32'h00C3_0000;
        tick();
        tick();
        check("rs_wr_s",    32'(d_wr_n),     32'h0);
        check("rs_grant_s", 32'(d_grant_id), 32'h2);
        #2;
        reset_n = 1'b0;
        #1;
        check("rs_wr",    32'(d_wr_n),      32'h1);
        check("rs_ready", 32'(d_src_ready), 32'h0);
        check("rs_busy",  32'(d_busy),      32'h0);
        check("rs_grant", 32'(d_grant_id),  32'h0);
        src_valid = 4'b1111;
        tick();
        reset_n = 1'b1;
        tick();
        check("rs_first", 32'(d_grant_id), 32'h0);
        check("rs_busy2", 32'(d_busy),     32'h1);
        $display("txn reset_strobe: grant=%0d busy=%0d", d_grant_id, d_busy);

        // ---------------- Two sources 0 and 2, BURST_MAX=2 ----------------
        do_reset();
        txe_n     = 1'b0;
        src_valid = 4'b0101;
        src_data  = 32'h0022_0000 | 32'h0000_0000;
        clear_log();
        for (int c = 1; c <= 28; c++) begin
            tick();
            if (b_wr_n == 1'b0 && n_st < 16) begin
                st_g[n_st] = 32'(b_grant_id);
                n_st++;
            end
        end
        check("pr_count", 32'(n_st), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check("pr_grant", st_g[k], 32'(exp_pg[k]));
            $display("txn pri strobe %0d: grant=%0d", k, st_g[k]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
